// File: rtl/reg_op_sequencer_if.sv
// Instruction handshake and register-bank bus of the op sequencer.
// master: instruction source and bank; slave: the sequencer.
interface reg_op_sequencer_if #(
    parameter int DATA_W = 8,
    parameter int NREGS  = 4
);
    logic                      instr_valid;
    logic [7:0]                instr;
    logic                      instr_ready;
    logic [NREGS*DATA_W-1:0]   reg_out_bus;
    logic [NREGS-1:0]          reg_rd_en;
    logic [NREGS-1:0]          reg_wr_en;
    logic [DATA_W-1:0]         reg_in;
    logic                      done;
    logic                      zero_flag;
    logic                      carry_flag;
    logic                      illegal;

    modport master (
        output instr_valid,
        output instr,
        output reg_out_bus,
        input  instr_ready,
        input  reg_rd_en,
        input  reg_wr_en,
        input  reg_in,
        input  done,
        input  zero_flag,
        input  carry_flag,
        input  illegal
    );

    modport slave (
        input  instr_valid,
        input  instr,
        input  reg_out_bus,
        output instr_ready,
        output reg_rd_en,
        output reg_wr_en,
        output reg_in,
        output done,
        output zero_flag,
        output carry_flag,
        output illegal
    );
endinterface

// File: rtl/reg_op_sequencer.sv
// Register-bank ALU sequencer: IDLE -> READ -> EXEC -> WRITE, or IDLE -> FIN.
// Every output is a flop loaded from the next-state logic.
module reg_op_sequencer #(
    parameter int DATA_W = 8,
    parameter int NREGS  = 4
) (
    input logic              reg_clk,
    input logic              reg_rst,
    reg_op_sequencer_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_EXEC,
        S_WRITE,
        S_FIN
    } state_t;

    localparam logic [3:0] OP_ADD = 4'd1;
    localparam logic [3:0] OP_SUB = 4'd2;
    localparam logic [3:0] OP_AND = 4'd3;
    localparam logic [3:0] OP_NOT = 4'd4;
    localparam logic [3:0] OP_MOV = 4'd5;

    function automatic logic [NREGS-1:0] f_onehot(input logic [1:0] idx);
        logic [NREGS-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    function automatic logic [DATA_W-1:0] f_slice(
        input logic [NREGS*DATA_W-1:0] v,
        input logic [1:0]              idx
    );
        return v[idx*DATA_W +: DATA_W];
    endfunction

    state_t             r_state;
    logic [7:0]         r_instr;
    logic [DATA_W-1:0]  r_a;
    logic [DATA_W-1:0]  r_b;
    logic [NREGS-1:0]   r_rd_en;
    logic [NREGS-1:0]   r_wr_en;
    logic [DATA_W-1:0]  r_reg_in;
    logic               r_done;
    logic               r_illegal;
    logic               r_zero;
    logic               r_carry;
    logic               r_ready;

    state_t             w_state_nxt;
    logic [7:0]         w_instr;
    logic [DATA_W-1:0]  w_a;
    logic [DATA_W-1:0]  w_b;
    logic [NREGS-1:0]   w_rd_en;
    logic [NREGS-1:0]   w_wr_en;
    logic [DATA_W-1:0]  w_reg_in;
    logic               w_done;
    logic               w_illegal;
    logic               w_zero;
    logic               w_carry;
    logic               w_ready;

    logic [3:0]         w_in_op;
    logic               w_in_alu;
    logic [DATA_W:0]    w_sum;
    logic [DATA_W:0]    w_diff;
    logic [DATA_W-1:0]  w_res;
    logic               w_cout;

    assign w_in_op  = bus.instr[7:4];
    assign w_in_alu = (w_in_op >= OP_ADD) && (w_in_op <= OP_MOV);
    assign w_sum    = {1'b0, r_a} + {1'b0, r_b};
    assign w_diff   = {1'b0, r_a} - {1'b0, r_b};

    // ALU on the captured operands; the borrow of A-B is A<B
    always_comb begin
        w_res  = r_b;
        w_cout = 1'b0;
        case (r_instr[7:4])
            OP_ADD: begin
                w_res  = w_sum[DATA_W-1:0];
                w_cout = w_sum[DATA_W];
            end
            OP_SUB: begin
                w_res  = w_diff[DATA_W-1:0];
                w_cout = w_diff[DATA_W];
            end
            OP_AND: w_res = r_a & r_b;
            OP_NOT: w_res = ~r_b;
            default: w_res = r_b;
        endcase
    end

    // Next state and next registered outputs
    always_comb begin
        w_state_nxt = r_state;
        w_instr     = r_instr;
        w_a         = r_a;
        w_b         = r_b;
        w_rd_en     = '0;
        w_wr_en     = '0;
        w_reg_in    = r_reg_in;
        w_done      = 1'b0;
        w_illegal   = 1'b0;
        w_zero      = r_zero;
        w_carry     = r_carry;
        w_ready     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.instr_valid) begin
                    w_instr = bus.instr;
                    if (w_in_alu) begin
                        w_state_nxt = S_READ;
                        w_rd_en     = f_onehot(bus.instr[3:2])
                                    | f_onehot(bus.instr[1:0]);
                    end else begin
                        w_state_nxt = S_FIN;
                        w_done      = 1'b1;
                        w_illegal   = (w_in_op > OP_MOV);
                    end
                end else begin
                    w_ready = 1'b1;
                end
            end
            S_READ: begin
                w_a         = f_slice(bus.reg_out_bus, r_instr[1:0]);
                w_b         = f_slice(bus.reg_out_bus, r_instr[3:2]);
                w_state_nxt = S_EXEC;
            end
            S_EXEC: begin
                w_reg_in    = w_res;
                w_wr_en     = f_onehot(r_instr[1:0]);
                w_done      = 1'b1;
                w_zero      = (w_res == '0);
                w_carry     = w_cout;
                w_state_nxt = S_WRITE;
            end
            S_WRITE: begin
                w_ready     = 1'b1;
                w_state_nxt = S_IDLE;
            end
            S_FIN: begin
                w_ready     = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_ready     = 1'b1;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset wins over any accept
    always_ff @(posedge reg_clk) begin
        if (reg_rst) begin
            r_state   <= S_IDLE;
            r_instr   <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_rd_en   <= '0;
            r_wr_en   <= '0;
            r_reg_in  <= '0;
            r_done    <= 1'b0;
            r_illegal <= 1'b0;
            r_zero    <= 1'b0;
            r_carry   <= 1'b0;
            r_ready   <= 1'b1;
        end else begin
            r_state   <= w_state_nxt;
            r_instr   <= w_instr;
            r_a       <= w_a;
            r_b       <= w_b;
            r_rd_en   <= w_rd_en;
            r_wr_en   <= w_wr_en;
            r_reg_in  <= w_reg_in;
            r_done    <= w_done;
            r_illegal <= w_illegal;
            r_zero    <= w_zero;
            r_carry   <= w_carry;
            r_ready   <= w_ready;
        end
    end

    assign bus.instr_ready = r_ready;
    assign bus.reg_rd_en   = r_rd_en;
    assign bus.reg_wr_en   = r_wr_en;
    assign bus.reg_in      = r_reg_in;
    assign bus.done        = r_done;
    assign bus.illegal     = r_illegal;
    assign bus.zero_flag   = r_zero;
    assign bus.carry_flag  = r_carry;

endmodule

// File: doc/reg_op_sequencer.md
REG_OP_SEQUENCER -- requirements
Module: reg_op_sequencer

Interface
REQ-001 Parameter DATA_W, default 8: register data width; only 8 is supported.
REQ-002 Parameter NREGS, default 4: number of bank registers; only 4 is supported.
REQ-003 reg_clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 reg_rst  input  1  reset, synchronous, active-high.
REQ-005 instr_valid  input  1  instruction offered.
REQ-006 instr  input  8  [7:4] opcode, [3:2] src index, [1:0] dest index.
REQ-007 instr_ready  output  1  sequencer accepts an instruction this cycle.
REQ-008 reg_out_bus  input  32  bank read bus; register i occupies bits [8i+7:8i]; unselected slices read 0.
REQ-009 reg_rd_en  output  4  one-hot-or-two-hot bank read enables.
REQ-010 reg_wr_en  output  4  at most one-hot bank write enable.
REQ-011 reg_in  output  8  write data to bank.
REQ-012 done  output  1  one-cycle pulse on instruction completion.
REQ-013 zero_flag  output  1  last ALU result was zero.
REQ-014 carry_flag  output  1  last ADD carry-out / SUB borrow.
REQ-015 illegal  output  1  one-cycle pulse, opcode undefined.

Function
REQ-016 The block SHALL implement FSM states IDLE, READ, EXEC, WRITE, FIN; all outputs registered.
REQ-017 IDLE: instr_ready=1; other states: instr_ready=0.
REQ-018 Accept = instr_valid & instr_ready at a rising edge; instr latched; instr ignored otherwise.
REQ-019 Opcodes: 0 NOP, 1 ADD, 2 SUB, 3 AND, 4 NOT, 5 MOV; 6-15 illegal.
REQ-020 On accept of opcode 1-5: IDLE->READ; of NOP or illegal: IDLE->FIN.
REQ-021 READ (one cycle): reg_rd_en = onehot(src) | onehot(dest); src==dest gives a single bit.
REQ-022 End of READ: capture A = reg_out_bus slice[dest], B = slice[src]; READ->EXEC.
REQ-023 EXEC (one cycle): reg_rd_en=0; compute result, 8-bit wrap: ADD A+B, SUB A-B, AND A&B, NOT ~B, MOV B; EXEC->WRITE.
REQ-024 Flags update at end of EXEC only: zero_flag = (result==0) for all ALU ops; carry_flag = carry-out for ADD, (A<B) for SUB, 0 for AND/NOT/MOV.
REQ-025 WRITE (one cycle): reg_in=result, reg_wr_en=onehot(dest), done=1; WRITE->IDLE.
REQ-026 FIN (one cycle): done=1, reg_wr_en=0; illegal=1 if opcode 6-15; flags unchanged; FIN->IDLE.
REQ-027 Latency from accept edge: ALU op done in 3rd cycle after accept, NOP/illegal in 1st; next accept earliest 1 cycle after done.
REQ-028 reg_rd_en SHALL be 0 outside READ; reg_wr_en 0 outside WRITE; reg_in holds last result when not writing.
REQ-029 instr_valid changes while not in IDLE SHALL have no effect.

Reset
REQ-030 reg_rst high at an edge SHALL force IDLE and clear reg_rd_en, reg_wr_en, reg_in, done, illegal, zero_flag, carry_flag, latched instr and operands; instr_ready=1 after.
REQ-031 Reset in any state including mid-WRITE SHALL abort the instruction; no write enable after the reset edge; no done pulse.
REQ-032 Reset SHALL take priority over a simultaneous accept.

Verification
REQ-033 Bank r1=0x0F, r2=0xF1; ADD dest=1 src=2 -> READ rd_en=0110, WRITE wr_en=0010 reg_in=0x00, zero=1, carry=1, done 3 cycles after accept.
REQ-034 r0=0x05, r3=0x07; SUB dest=0 src=3 -> reg_in=0xFE, wr_en=0001, carry=1, zero=0.
REQ-035 MOV dest=2 src=2 (r2=0x5A) -> rd_en=0100, reg_in=0x5A, carry=0.
REQ-036 opcode 0xB -> FIN next cycle: done=1, illegal=1, wr_en=0, flags unchanged; NOP same with illegal=0.
REQ-037 instr_valid held high with 3 ALU ops queued -> accepts exactly every 4 cycles, instr changes while busy ignored.
REQ-038 Assert reg_rst during WRITE of ADD -> next cycle all outputs 0, instr_ready=1, no done pulse.
